// File: rtl/cpu_mem_access_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_access_if
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   master (MEM stage): drives req, we, be, addr, wdata; samples ack, rdata
//   slave  (memory)   : samples req, we, be, addr, wdata; drives ack, rdata
// Signals:
//   req   - bus request, held high until ack
//   we    - 1 = store, 0 = load
//   be    - little-endian byte enables
//   addr  - word-aligned byte address
//   wdata - lane-replicated store data
//   ack   - transaction complete, rdata valid in the same cycle
//   rdata - read word
// ----------------------------------------------------------------------------
interface cpu_mem_access_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req;
  logic                  we;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  ack;
  logic [31:0]           rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/cpu_mem_access.sv
// ----------------------------------------------------------------------------
// cpu_mem_access
// MEM pipeline stage between EX and WB. Non-memory instructions pass through
// with one cycle of latency; loads/stores run a req/ack transaction on the
// data-memory bus (stage stalls with ready_o low while it is outstanding).
// Misaligned accesses and bus timeouts retire as error pulses.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   valid_i / ready_o             EX handshake (accept = valid_i & ready_o)
//   mem_op_i, we_i, waddr_i,
//   wdata_i, maddr_i, sdata_i     instruction presented by EX
//   dmem                          data-memory bus (master side)
//   wb_valid_o, we_o, waddr_o,
//   wdata_o                       retired result to WB (one-cycle pulse)
//   adel_o, ades_o, bus_err_o,
//   badvaddr_o                    error pulses and faulting address
// ----------------------------------------------------------------------------
module cpu_mem_access #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [3:0]                mem_op_i,
  input  logic                      we_i,
  input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]               wdata_i,
  input  logic [ADDR_WIDTH-1:0]     maddr_i,
  input  logic [31:0]               sdata_i,
  cpu_mem_access_if.master          dmem,
  output logic                      wb_valid_o,
  output logic                      we_o,
  output logic [REG_ADDR_WIDTH-1:0] waddr_o,
  output logic [31:0]               wdata_o,
  output logic                      adel_o,
  output logic                      ades_o,
  output logic                      bus_err_o,
  output logic [ADDR_WIDTH-1:0]     badvaddr_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam int              CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Extracts the addressed byte/half from the read word and extends it.
  function automatic logic [31:0] load_extract(input logic [3:0] op,
                                               input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Byte enables for the access; loads always read the whole word.
  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] off);
    logic [3:0] be;
    case (op)
      OP_SB:   be = 4'b0001 << off;
      OP_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so memory can just apply be.
  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] sdata);
    logic [31:0] w;
    case (op)
      OP_SB:   w = {4{sdata[7:0]}};
      OP_SH:   w = {2{sdata[15:0]}};
      OP_SW:   w = sdata;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      req_q, req_d;
  logic                      dwe_q, dwe_d;
  logic [3:0]                be_q, be_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [31:0]               dwdata_q, dwdata_d;
  logic [3:0]                op_q, op_d;
  logic                      lwe_q, lwe_d;
  logic [REG_ADDR_WIDTH-1:0] lwaddr_q, lwaddr_d;
  logic [ADDR_WIDTH-1:0]     maddr_q, maddr_d;
  logic                      wb_valid_q, wb_valid_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      adel_q, adel_d;
  logic                      ades_q, ades_d;
  logic                      bus_err_q, bus_err_d;
  logic [ADDR_WIDTH-1:0]     badvaddr_q, badvaddr_d;

  logic is_mem;
  logic is_load;
  logic misaligned;

  // Decode of the incoming memory operation.
  always_comb begin
    is_mem     = 1'b0;
    is_load    = 1'b0;
    misaligned = 1'b0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin
        is_mem  = 1'b1;
        is_load = 1'b1;
      end
      OP_LH, OP_LHU: begin
        is_mem     = 1'b1;
        is_load    = 1'b1;
        misaligned = maddr_i[0];
      end
      OP_LW: begin
        is_mem     = 1'b1;
        is_load    = 1'b1;
        misaligned = |maddr_i[1:0];
      end
      OP_SB: begin
        is_mem = 1'b1;
      end
      OP_SH: begin
        is_mem     = 1'b1;
        misaligned = maddr_i[0];
      end
      OP_SW: begin
        is_mem     = 1'b1;
        misaligned = |maddr_i[1:0];
      end
      default: begin
        is_mem = 1'b0;
      end
    endcase
  end

  // Next-state logic: bus signals hold in WAIT; WB outputs are single-cycle pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    dwe_d      = dwe_q;
    be_d       = be_q;
    addr_d     = addr_q;
    dwdata_d   = dwdata_q;
    op_d       = op_q;
    lwe_d      = lwe_q;
    lwaddr_d   = lwaddr_q;
    maddr_d    = maddr_q;
    wb_valid_d = 1'b0;
    we_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = 32'd0;
    adel_d     = 1'b0;
    ades_d     = 1'b0;
    bus_err_d  = 1'b0;
    badvaddr_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            we_d       = we_i;
            waddr_d    = waddr_i;
            wdata_d    = wdata_i;
          end else if (misaligned) begin
            wb_valid_d = 1'b1;
            adel_d     = is_load;
            ades_d     = !is_load;
            badvaddr_d = maddr_i;
          end else begin
            state_d  = ST_WAIT;
            cnt_d    = '0;
            req_d    = 1'b1;
            dwe_d    = !is_load;
            be_d     = lane_be(mem_op_i, maddr_i[1:0]);
            addr_d   = {maddr_i[ADDR_WIDTH-1:2], 2'b00};
            dwdata_d = lane_wdata(mem_op_i, sdata_i);
            op_d     = mem_op_i;
            lwe_d    = we_i;
            lwaddr_d = waddr_i;
            maddr_d  = maddr_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Ack wins over a timeout landing on the same edge.
        if (dmem.ack) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          dwe_d      = 1'b0;
          be_d       = 4'b0000;
          addr_d     = '0;
          dwdata_d   = 32'd0;
          wb_valid_d = 1'b1;
          if (!dwe_q) begin
            we_d    = lwe_q;
            waddr_d = lwaddr_q;
            wdata_d = load_extract(op_q, maddr_q[1:0], dmem.rdata);
          end else begin
            we_d = 1'b0;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          dwe_d      = 1'b0;
          be_d       = 4'b0000;
          addr_d     = '0;
          dwdata_d   = 32'd0;
          wb_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          badvaddr_d = maddr_q;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset also kills any bus request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      dwe_q      <= 1'b0;
      be_q       <= 4'b0000;
      addr_q     <= '0;
      dwdata_q   <= 32'd0;
      op_q       <= 4'd0;
      lwe_q      <= 1'b0;
      lwaddr_q   <= '0;
      maddr_q    <= '0;
      wb_valid_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      dwe_q      <= dwe_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      dwdata_q   <= dwdata_d;
      op_q       <= op_d;
      lwe_q      <= lwe_d;
      lwaddr_q   <= lwaddr_d;
      maddr_q    <= maddr_d;
      wb_valid_q <= wb_valid_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      adel_q     <= adel_d;
      ades_q     <= ades_d;
      bus_err_q  <= bus_err_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // ready is held low while reset is asserted, even though the state is IDLE.
  assign ready_o    = (state_q == ST_IDLE) && !rst;
  assign dmem.req   = req_q;
  assign dmem.we    = dwe_q;
  assign dmem.be    = be_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = dwdata_q;
  assign wb_valid_o = wb_valid_q;
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign adel_o     = adel_q;
  assign ades_o     = ades_q;
  assign bus_err_o  = bus_err_q;
  assign badvaddr_o = badvaddr_q;

endmodule
